uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single transmit channel of the `uart` block between `N_REQ` byte producers, such as the RX echo path and an ASCII message sender. It grants one byte at a time, arbitrating round-robin by default. It drives `tx_start`/`tx_data` into `uart` and tracks `tx_busy` until the byte has left the line. A watchdog recovers if `tx_busy` never rises after a start pulse.

## Interface
- `N_REQ`, default 2: number of requesters; legal range 2..8.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `tx_busy` to rise after `tx_start`; legal range 2..255.
- `clk`  input  1  system clock; all logic rising-edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  N_REQ  per-requester level request; bit i high means `data[8i+7:8i]` is valid.
- `data`  input  8*N_REQ  packed request bytes; requester i occupies `[8i+7:8i]`.
- `ack`  output  N_REQ  one-cycle pulse; the byte from requester i was taken.
- `grant`  output  N_REQ  one-hot owner of the byte in flight; 0 when idle.
- `tx_start`  output  1  one-cycle start pulse to `uart`.
- `tx_data`  output  8  byte to `uart`; held stable from `tx_start` until IDLE.
- `tx_busy`  input  1  busy flag from `uart`.
- `timeout_err`  output  1  one-cycle pulse; `tx_busy` failed to rise within `BUSY_TIMEOUT`.

## Operation
- States:
  - IDLE: sample `req`.
    - No bit of `req` is set: stay in IDLE.
    - Winner w found: register `ack[w]=1`, `tx_start=1`, `tx_data=data[w]`, `grant[w]=1`, set `last=w`, clear `tcnt`, go to WAIT_HI.
  - WAIT_HI: `ack`/`tx_start` return to 0 here.
    - `tx_busy=1`: go to WAIT_LO.
    - Else, `tcnt==BUSY_TIMEOUT-1`: pulse `timeout_err`, clear `grant`, go to IDLE.
    - Else: `tcnt++`.
  - WAIT_LO: when `tx_busy=0`, clear `grant` and go to IDLE.
- Round-robin rule:
  - Search starts at `(last+1) mod N_REQ` and wraps; the first set `req` bit wins.
  - `last` resets to `N_REQ-1`, so requester 0 wins first.
- Requester rules:
  - Hold `req` and `data` stable until `ack` is seen.
  - At the edge where `ack` is high, drop `req` or present the next byte.
  - `req` is not sampled outside IDLE, so requests raised mid-transfer wait.
- `tcnt` is 8-bit and never wraps.
- A timed-out byte is counted as consumed: it was acked and is not retried.
- Asynchronous reset mid-transfer:
  - Returns to IDLE immediately.
  - `last=N_REQ-1`.
  - Every output, including `tx_data` and `tcnt`, is 0.
  - No residual `ack` or `tx_start`.

## Timing
- Request-to-start latency: 1 cycle. `req` sampled at edge k gives `ack` and `tx_start` high during cycle k+1.
- `ack` and `tx_start` are always coincident and exactly 1 cycle wide.
- Return to IDLE: 1 cycle after `tx_busy` is seen low in WAIT_LO.
- The next grant follows 1 cycle after that, giving a minimum 2-cycle gap after `tx_busy` falls.
- Timeout: `timeout_err` fires `BUSY_TIMEOUT` cycles after the `tx_start` cycle, and the FSM is back in IDLE 1 cycle later.
- All outputs are registered; no combinational path from `req` to `ack`.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `last` is not used and not updated.
  - Undefined (default): round-robin as above.
  - Ports, latency and timeout behaviour are identical in both builds.

## Test plan
- Single requester: `req=2'b01`, `data[7:0]=8'h41`, `uart` model raises `tx_busy` 1 cycle after start for 20 cycles. Required:
  - `ack[0]` and `tx_start` for 1 cycle, `tx_data=8'h41`.
  - `grant=2'b01` until 1 cycle after `tx_busy` falls.
- Contention, default build: `req=2'b11` held, `data=16'h4241`, requesters re-present the same bytes after each `ack`. Required:
  - Grants alternate 0,1,0,1.
  - `tx_data` sequence 41,42,41,42.
- Fixed-priority build (`UART_ARB_FIXED_PRIO_EN`): same stimulus as contention. Required:
  - Only requester 0 is served.
  - `tx_data` is always 41 and `ack[1]` never pulses.
- Timeout: `req=2'b10`, `tx_busy` tied 0, `BUSY_TIMEOUT=16`. Required:
  - `timeout_err` pulses exactly 16 cycles after `tx_start`.
  - `ack[1]` pulses once, FSM returns to IDLE, and the next request is granted normally.
- Mid-transfer request: raise `req[1]` while in WAIT_LO. Required:
  - No `ack[1]` until IDLE.
  - Then `ack[1]` follows exactly 1 cycle after IDLE is entered.
- Reset in WAIT_LO with `tx_busy=1`. Required:
  - All outputs are 0 immediately.
  - After release with `req=2'b11`, requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit channel between N_REQ byte producers, one byte per grant.
// Round-robin by default; define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] TCNT_LAST = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t           state;
  logic [7:0]       tcnt;
  logic             win_vld;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win_oh;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`else
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
  localparam logic [IW:0]   NR       = (IW+1)'(N_REQ);

  logic [IW-1:0] last;
  logic [IW:0]   cand;

  // Search starts one past the previous winner and wraps modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last} + (IW+1)'(k);
      if (cand >= NR) cand = cand - NR;
      if (!win_vld && req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= LAST_RST;
    end else if (state == IDLE && win_vld) begin
      last <= win_idx;
    end
  end
`endif

  assign win_oh = N_REQ'(1) << win_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      ack         <= '0;
      grant       <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            ack      <= win_oh;
            grant    <= win_oh;
            tx_start <= 1'b1;
            tx_data  <= data[{win_idx, 3'b000} +: 8];
            tcnt     <= '0;
            state    <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (tcnt == TCNT_LAST) begin
            // The byte was already acked, so it is dropped rather than retried.
            timeout_err <= 1'b1;
            grant       <= '0;
            state       <= IDLE;
          end else if (tcnt != 8'hFF) begin
            tcnt <= tcnt + 8'd1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (N_REQ=2, BUSY_TIMEOUT=16); the UART busy flag is driven by hand.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] data;
  logic [1:0]  ack;
  logic [1:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        timeout_err;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_arbiter #(.N_REQ(2), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Called in the tx_start cycle: busy high for hi_cycles, then low, ending in IDLE.
  task automatic serve(input int hi_cycles);
    tx_busy = 1'b1;
    repeat (hi_cycles) begin
      tick();
      check("busy_grant_held", 16'(|grant), 16'd1);
    end
    tx_busy = 1'b0;
    tick();
    check("idle_grant_clear", 16'(grant), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_idx;
    reset   = 1'b1;
    req     = 2'b00;
    data    = 16'h0000;
    tx_busy = 1'b0;
    tick();
    tick();
    check("rst_ack",     16'(ack), 16'd0);
    check("rst_grant",   16'(grant), 16'd0);
    check("rst_start",   16'(tx_start), 16'd0);
    check("rst_data",    16'(tx_data), 16'd0);
    check("rst_timeout", 16'(timeout_err), 16'd0);
    reset = 1'b0;
    tick();

    // Single requester, busy rises one cycle after start and lasts 20 cycles.
    req  = 2'b01;
    data = 16'h0041;
    tick();
    check("single_ack",   16'(ack), 16'h0001);
    check("single_start", 16'(tx_start), 16'd1);
    check("single_data",  16'(tx_data), 16'h0041);
    check("single_grant", 16'(grant), 16'h0001);
    req = 2'b00;
    tick();
    check("single_ack_drop",   16'(ack), 16'd0);
    check("single_start_drop", 16'(tx_start), 16'd0);
    tx_busy = 1'b1;
    repeat (20) begin
      tick();
      check("single_grant_busy", 16'(grant), 16'h0001);
    end
    tx_busy = 1'b0;
    tick();
    check("single_grant_end", 16'(grant), 16'd0);

    // Contention from a fresh reset: both requesters hold their bytes.
    pulse_reset();
    req  = 2'b11;
    data = 16'h4241;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef UART_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = i % 2;
`endif
      check("cont_ack",   16'(ack), 16'(1 << exp_idx));
      check("cont_start", 16'(tx_start), 16'd1);
      check("cont_data",  16'(tx_data), 16'(8'h41 + exp_idx));
      serve(3);
    end
    req = 2'b00;

    // Timeout: busy never rises.
    req  = 2'b10;
    tick();
    check("to_ack",   16'(ack), 16'h0002);
    check("to_start", 16'(tx_start), 16'd1);
    check("to_data",  16'(tx_data), 16'h0042);
    req = 2'b00;
    for (int j = 1; j < 16; j++) begin
      tick();
      check("to_err_early", 16'({ack, timeout_err}), 16'd0);
    end
    tick();
    check("to_err_pulse", 16'(timeout_err), 16'd1);
    check("to_grant",     16'(grant), 16'd0);
    req = 2'b01;
    tick();
    check("to_err_clear", 16'(timeout_err), 16'd0);
    check("to_next_ack",  16'(ack), 16'h0001);
    check("to_next_data", 16'(tx_data), 16'h0041);
    req = 2'b00;
    serve(2);

    // Request raised while the previous byte is on the line.
    req = 2'b01;
    tick();
    check("mid_ack0", 16'(ack), 16'h0001);
    req     = 2'b00;
    tx_busy = 1'b1;
    tick();
    req = 2'b10;
    repeat (3) begin
      tick();
      check("mid_no_ack", 16'(ack), 16'd0);
    end
    tx_busy = 1'b0;
    tick();
    check("mid_idle_ack",   16'(ack), 16'd0);
    check("mid_idle_grant", 16'(grant), 16'd0);
    tick();
    check("mid_ack1",  16'(ack), 16'h0002);
    check("mid_data1", 16'(tx_data), 16'h0042);
    req = 2'b00;
    serve(2);

    // Asynchronous reset while in WAIT_LO with busy high.
    req = 2'b01;
    tick();
    check("rwl_ack", 16'(ack), 16'h0001);
    req     = 2'b00;
    tx_busy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rwl_grant", 16'(grant), 16'd0);
    check("rwl_data",  16'(tx_data), 16'd0);
    check("rwl_start", 16'({ack, tx_start, timeout_err}), 16'd0);
    req = 2'b11;
    tick();
    check("rwl_held_ack", 16'(ack), 16'd0);
    reset   = 1'b0;
    tx_busy = 1'b0;
    tick();
    check("rwl_first_ack",  16'(ack), 16'h0001);
    check("rwl_first_data", 16'(tx_data), 16'h0041);
    req = 2'b00;
    serve(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
